// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the seven-segment scan controller.
// Segment order is gfedcba, active-high.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; non-BCD nibbles show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  bcd_t       i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed BCD seven-segment scan controller with frame-synchronous value updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero one.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 16
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic                    load_i,
   output logic                    load_ack_o,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   state_t                  r_state, w_stateNext;
   logic [IDX_W-1:0]        r_idx, w_idxNext, w_idxInc;
   logic [CNT_W-1:0]        r_cnt, w_cntNext;
   logic                    r_armed;
   logic [4*NUM_DIGITS-1:0] r_shadow, w_shadowNext;
   logic [4*NUM_DIGITS-1:0] r_pending, w_pendingNext;
   logic                    r_pendValid, w_pendValidNext;
   logic [6:0]              r_seg, w_segNext;
   logic [NUM_DIGITS-1:0]   r_an, w_anNext;
   logic                    r_frame, w_frameNext;
   logic                    r_ack, w_ackNext;
   bcd_t                    w_nibble;
   logic [6:0]              w_decSeg;
   logic                    w_blankDigit;

   assign w_idxInc = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

   // Outputs are registered from next-cycle values so they line up with the state they show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_shadow    <= '0;
         r_pending   <= '0;
         r_pendValid <= 1'b0;
         r_seg       <= '0;
         r_an        <= '0;
         r_frame     <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_idx       <= w_idxNext;
         r_cnt       <= w_cntNext;
         r_armed     <= 1'b1;
         r_shadow    <= w_shadowNext;
         r_pending   <= w_pendingNext;
         r_pendValid <= w_pendValidNext;
         r_seg       <= w_segNext;
         r_an        <= w_anNext;
         r_frame     <= w_frameNext;
         r_ack       <= w_ackNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_idxNext   = r_idx;
      w_cntNext   = r_cnt;
      if (!ena) begin
         w_stateNext = ST_IDLE;
         w_idxNext   = '0;
         w_cntNext   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_armed) begin
                  w_stateNext = ST_DWELL;
                  w_idxNext   = '0;
                  w_cntNext   = '0;
               end
            end
            ST_DWELL: begin
               if (r_cnt == DWELL_LAST) begin
                  w_cntNext = '0;
                  if (BLANK_CYCLES > 0) w_stateNext = ST_BLANK;
                  else                  w_idxNext   = w_idxInc;
               end else begin
                  w_cntNext = r_cnt + 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_stateNext = ST_DWELL;
                  w_idxNext   = w_idxInc;
                  w_cntNext   = '0;
               end else begin
                  w_cntNext = r_cnt + 1'b1;
               end
            end
            default: begin
               w_stateNext = ST_IDLE;
               w_idxNext   = '0;
               w_cntNext   = '0;
            end
         endcase
      end
   end

   // r_frame marks the current cycle as the frame boundary, the only point the shadow may change.
   always_comb begin
      w_shadowNext    = r_shadow;
      w_pendingNext   = r_pending;
      w_pendValidNext = r_pendValid;
      w_ackNext       = 1'b0;
      if (r_frame) begin
         if (load_i) begin
            w_shadowNext = digits_i;
            w_ackNext    = 1'b1;
         end else if (r_pendValid) begin
            w_shadowNext = r_pending;
            w_ackNext    = 1'b1;
         end
         w_pendValidNext = 1'b0;
      end else if (load_i) begin
         w_pendingNext   = digits_i;
         w_pendValidNext = 1'b1;
      end
   end

   assign w_nibble = w_shadowNext[{w_idxNext, 2'b00} +: 4];

   bcd_to_seg7 u_decode (
      .i_bcd (w_nibble),
      .o_seg (w_decSeg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      w_blankDigit = 1'b0;
      if (w_idxNext != '0)
         w_blankDigit = ((w_shadowNext >> {w_idxNext, 2'b00}) == '0);
   end
`else
   assign w_blankDigit = 1'b0;
`endif

   always_comb begin
      w_anNext    = '0;
      w_segNext   = SEG_OFF;
      w_frameNext = 1'b0;
      if (w_stateNext == ST_DWELL) begin
         w_anNext  = NUM_DIGITS'(1) << w_idxNext;
         w_segNext = w_blankDigit ? SEG_OFF : w_decSeg;
      end
      if (w_idxNext == IDX_LAST) begin
         if (BLANK_CYCLES > 0)
            w_frameNext = (w_stateNext == ST_BLANK) && (w_cntNext == BLANK_LAST);
         else
            w_frameNext = (w_stateNext == ST_DWELL) && (w_cntNext == DWELL_LAST);
      end
   end

   assign seg_o      = r_seg;
   assign an_o       = r_an;
   assign frame_o    = r_frame;
   assign load_ack_o = r_ack;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, dwell 4, blank 2).
// Honours LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DW    = 4;
   localparam int BL    = 2;
   localparam int SLOT  = DW + BL;
   localparam int FRAME = N * SLOT;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        load_i = 1'b0;
   logic [15:0] digits_i = 16'h0;
   logic        load_ack_o;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic        frame_o;

   int nCompared = 0;
   int nMismatched = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .digits_i   (digits_i),
      .load_i     (load_i),
      .load_ack_o (load_ack_o),
      .seg_o      (seg_o),
      .an_o       (an_o),
      .frame_o    (frame_o)
   );

   always #5 clk = ~clk;

   logic [6:0] segTab [16];
   initial begin
      segTab[0] = 7'h3F; segTab[1] = 7'h06; segTab[2] = 7'h5B; segTab[3] = 7'h4F;
      segTab[4] = 7'h66; segTab[5] = 7'h6D; segTab[6] = 7'h7D; segTab[7] = 7'h07;
      segTab[8] = 7'h7F; segTab[9] = 7'h6F;
      for (int i = 10; i < 16; i++) segTab[i] = 7'h40;
   end

   // Model: position within a running frame plus the displayed / pending values.
   bit          mArmed, mActive, mPendValid, mAck;
   int          mPos;
   logic [15:0] mShadow, mPend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mArmed <= 0; mActive <= 0; mPendValid <= 0; mAck <= 0;
         mPos <= 0; mShadow <= 16'h0; mPend <= 16'h0;
      end else begin
         if (mActive && mPos == FRAME - 1) begin
            mAck       <= load_i || mPendValid;
            mPendValid <= 0;
            if (load_i)          mShadow <= digits_i;
            else if (mPendValid) mShadow <= mPend;
         end else begin
            mAck <= 0;
            if (load_i) begin
               mPend      <= digits_i;
               mPendValid <= 1;
            end
         end
         if (!ena)          mActive <= 0;
         else if (!mActive) begin
            if (mArmed) begin
               mActive <= 1;
               mPos    <= 0;
            end
         end else           mPos <= (mPos + 1) % FRAME;
         mArmed <= 1;
      end
   end

   function automatic logic [3:0] expAn();
      if (!mActive || (mPos % SLOT) >= DW) return 4'b0000;
      return 4'(1 << (mPos / SLOT));
   endfunction

   function automatic logic [6:0] expSeg();
      int         d;
      logic [3:0] nib;
      if (!mActive || (mPos % SLOT) >= DW) return 7'h00;
      d   = mPos / SLOT;
      nib = 4'(mShadow >> (4 * d));
      if (LZB && d > 0 && (mShadow >> (4 * d)) == 16'h0) return 7'h00;
      return segTab[nib];
   endfunction

   function automatic logic expFrame();
      return mActive && (mPos == FRAME - 1);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("model an_o", {28'h0, an_o}, {28'h0, expAn()});
      checkOutput("model seg_o", {25'h0, seg_o}, {25'h0, expSeg()});
      checkOutput("model frame_o", {31'h0, frame_o}, {31'h0, expFrame()});
      checkOutput("model load_ack_o", {31'h0, load_ack_o}, {31'h0, mAck});
   end

   int cyc = 0;
   int firstFrame = -1;
   int secondFrame = -1;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (frame_o) begin
         if (firstFrame < 0)       firstFrame <= cyc;
         else if (secondFrame < 0) secondFrame <= cyc;
      end
   end

   task automatic applyStimulus(input logic e, input logic l, input logic [15:0] d);
      ena = e; load_i = l; digits_i = d;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitFrame();
      bit found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         step(1);
         if (frame_o) found = 1;
      end
      if (!found) checkOutput("frame_o timeout", {31'h0, frame_o}, 32'h1);
   endtask

   task automatic checkDisplay(input string name, input logic [3:0] an, input logic [6:0] seg);
      checkOutput({name, " an_o"}, {28'h0, an_o}, {28'h0, an});
      checkOutput({name, " seg_o"}, {25'h0, seg_o}, {25'h0, seg});
   endtask

   initial begin
      applyStimulus(0, 0, 16'h0);
      #23;
      checkDisplay("reset", 4'b0000, 7'h00);
      checkOutput("reset frame_o", {31'h0, frame_o}, 32'h0);
      checkOutput("reset load_ack_o", {31'h0, load_ack_o}, 32'h0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(1, 1, 16'h1234);
      step(1);
      applyStimulus(1, 0, 16'h1234);
      checkOutput("idle one edge after release", {28'h0, an_o}, 32'h0);
      step(1);
      checkDisplay("first dwell shows zero", 4'b0001, 7'h3F);

      step(24);
      checkOutput("ack after first frame", {31'h0, load_ack_o}, 32'h1);
      checkDisplay("1234 digit0", 4'b0001, 7'h66);
      step(1);
      checkOutput("ack one cycle wide", {31'h0, load_ack_o}, 32'h0);
      step(5);
      checkDisplay("1234 digit1", 4'b0010, 7'h4F);
      step(6);
      checkDisplay("1234 digit2", 4'b0100, 7'h5B);
      step(6);
      checkDisplay("1234 digit3", 4'b1000, 7'h06);
      step(4);
      checkDisplay("1234 blank", 4'b0000, 7'h00);

      waitFrame();
      step(1);
      checkOutput("no ack without load", {31'h0, load_ack_o}, 32'h0);
      applyStimulus(1, 1, 16'h0005);
      step(1);
      applyStimulus(1, 0, 16'h0);
      step(9);
      applyStimulus(1, 1, 16'h0007);
      step(1);
      applyStimulus(1, 0, 16'h0);
      waitFrame();
      step(1);
      checkOutput("last load wins ack", {31'h0, load_ack_o}, 32'h1);
      checkDisplay("last load wins digit0", 4'b0001, 7'h07);
      step(6);
      checkDisplay("0007 digit1", 4'b0010, LZB ? 7'h00 : 7'h3F);

      waitFrame();
      applyStimulus(1, 1, 16'h00A0);
      step(1);
      applyStimulus(1, 0, 16'h0);
      checkOutput("boundary load ack", {31'h0, load_ack_o}, 32'h1);
      checkDisplay("00A0 digit0", 4'b0001, 7'h3F);
      step(6);
      checkDisplay("00A0 dash", 4'b0010, 7'h40);

      applyStimulus(1, 1, 16'h0005);
      step(1);
      applyStimulus(1, 0, 16'h0);
      waitFrame();
      step(1);
      checkDisplay("0005 digit0", 4'b0001, 7'h6D);
      step(6);
      checkDisplay("0005 digit1", 4'b0010, LZB ? 7'h00 : 7'h3F);
      step(6);
      checkDisplay("0005 digit2", 4'b0100, LZB ? 7'h00 : 7'h3F);

      step(1);
      applyStimulus(0, 0, 16'h0);
      step(1);
      checkDisplay("ena drop idle", 4'b0000, 7'h00);
      step(2);
      applyStimulus(1, 0, 16'h0);
      step(1);
      checkDisplay("restart at digit0", 4'b0001, 7'h6D);

      applyStimulus(1, 1, 16'h0003);
      step(1);
      applyStimulus(1, 0, 16'h0);
      step(3);
      #2;
      rst_n = 1'b0;
      #1;
      checkDisplay("async reset", 4'b0000, 7'h00);
      checkOutput("async reset frame_o", {31'h0, frame_o}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(2);
      checkDisplay("after reset shows zero", 4'b0001, 7'h3F);
      waitFrame();
      step(1);
      checkOutput("pending lost by reset", {31'h0, load_ack_o}, 32'h0);
      checkDisplay("after reset frame", 4'b0001, 7'h3F);

      checkOutput("frame period", firstFrame < 0 ? 32'h0 : 32'(secondFrame - firstFrame), 32'd24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
